// File: rtl/lexer_pkg.sv
// Shared constants for the lexer: token kinds, ASCII codes, FSM encoding
// and character-class helpers.
package lexer_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned VALUE_W = 32;
  localparam int unsigned KIND_W  = 4;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 3;

  localparam logic [KIND_W-1:0] KIND_NUM   = 4'd0;
  localparam logic [KIND_W-1:0] KIND_SYM   = 4'd1;
  localparam logic [KIND_W-1:0] KIND_IDENT = 4'd2;
  localparam logic [KIND_W-1:0] KIND_EOF   = 4'd3;
  localparam logic [KIND_W-1:0] KIND_ERR   = 4'd4;

  localparam logic [BYTE_W-1:0] CH_SPACE = 8'h20;
  localparam logic [BYTE_W-1:0] CH_TAB   = 8'h09;
  localparam logic [BYTE_W-1:0] CH_LF    = 8'h0A;
  localparam logic [BYTE_W-1:0] CH_CR    = 8'h0D;
  localparam logic [BYTE_W-1:0] CH_NUL   = 8'h00;
  localparam logic [BYTE_W-1:0] CH_EQ    = 8'h3D;
  localparam logic [BYTE_W-1:0] CH_BANG  = 8'h21;
  localparam logic [BYTE_W-1:0] CH_LT    = 8'h3C;
  localparam logic [BYTE_W-1:0] CH_GT    = 8'h3E;
  localparam logic [BYTE_W-1:0] CH_0     = 8'h30;
  localparam logic [BYTE_W-1:0] CH_9     = 8'h39;
  localparam logic [BYTE_W-1:0] CH_UA    = 8'h41;
  localparam logic [BYTE_W-1:0] CH_UZ    = 8'h5A;
  localparam logic [BYTE_W-1:0] CH_LA    = 8'h61;
  localparam logic [BYTE_W-1:0] CH_LZ    = 8'h7A;
  localparam logic [BYTE_W-1:0] CH_UNDER = 8'h5F;

  localparam logic [STATE_W-1:0] ST_SKIP  = 3'd0;
  localparam logic [STATE_W-1:0] ST_NUM   = 3'd1;
  localparam logic [STATE_W-1:0] ST_IDENT = 3'd2;
  localparam logic [STATE_W-1:0] ST_OP2   = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

  function automatic logic is_digit(input logic [BYTE_W-1:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

  // Identifier start characters: letters and underscore.
  function automatic logic is_alpha(input logic [BYTE_W-1:0] c);
    return ((c >= CH_UA) && (c <= CH_UZ)) || ((c >= CH_LA) && (c <= CH_LZ)) || (c == CH_UNDER);
  endfunction

  function automatic logic is_ws(input logic [BYTE_W-1:0] c);
    return (c == CH_SPACE) || (c == CH_TAB) || (c == CH_LF) || (c == CH_CR);
  endfunction

  function automatic logic is_op2(input logic [BYTE_W-1:0] c);
    return (c == CH_EQ) || (c == CH_BANG) || (c == CH_LT) || (c == CH_GT);
  endfunction

  function automatic logic is_sym(input logic [BYTE_W-1:0] c);
    logic r;
    case (c)
      8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h28, 8'h29,
      8'h7B, 8'h7D, 8'h3B, 8'h2C, 8'h26: r = 1'b1;
      default:                           r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lexer_ibuf.sv
// Two-entry byte buffer in front of the lexer FSM, issuing FIFO reads so that
// buffered plus in-flight bytes never exceed two.
module lexer_ibuf
  import lexer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              empty,
  input  logic              valid,
  input  logic [BYTE_W-1:0] data,
  input  logic              pop,
  input  logic              done,
  output logic              rden_c,
  output logic [BYTE_W-1:0] head,
  output logic              head_valid
);

  logic [1:0]        occ;
  logic              inflight;
  logic [BYTE_W-1:0] b1;
  logic [1:0]        occ_after_pop;
  logic              push;

  // Space check accounts for this cycle's pop so a full buffer still streams.
  always_comb begin
    occ_after_pop = occ - 2'(pop);
    rden_c        = !rst && !empty && !done &&
                    (({1'b0, occ_after_pop} + 3'(inflight)) < 3'd2);
  end

  assign push       = valid && inflight;
  assign head_valid = (occ != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      head     <= '0;
      b1       <= '0;
    end else begin
      inflight <= rden_c;
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= data;
          else             b1   <= data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= b1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head <= data;
          end else begin
            head <= b1;
            b1   <= data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lexer.sv
// Tokenizer: pulls ASCII bytes from the fetch FIFO, skips whitespace and
// emits NUM/SYM/IDENT/EOF/ERR tokens over a valid/ready interface.
module lexer
  import lexer_pkg::*;
(
  input  logic               CCLK,
  input  logic               CRST,
  input  logic               I_EMPTY,
  output logic               I_RDEN,
  input  logic               I_VALID,
  input  logic [BYTE_W-1:0]  I_DATA,
  output logic               O_VALID,
  input  logic               O_READY,
  output logic [KIND_W-1:0]  O_KIND,
  output logic [VALUE_W-1:0] O_VALUE,
  output logic               O_DONE
);

  logic [STATE_W-1:0] state, state_nxt;
  logic [VALUE_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [BYTE_W-1:0]  first, first_nxt;
  logic [BYTE_W-1:0]  head;
  logic               head_valid;
  logic               pop_c;
  logic               emit_c;
  logic [KIND_W-1:0]  ekind_c;
  logic [VALUE_W-1:0] evalue_c;
  logic               out_free_c;

  lexer_ibuf u_ibuf (
    .clk        (CCLK),
    .rst        (CRST),
    .empty      (I_EMPTY),
    .valid      (I_VALID),
    .data       (I_DATA),
    .pop        (pop_c),
    .done       (state == ST_DONE),
    .rden_c     (I_RDEN),
    .head       (head),
    .head_valid (head_valid)
  );

  assign out_free_c = !O_VALID || O_READY;

  always_ff @(posedge CCLK) begin
    if (CRST) state <= ST_SKIP;
    else      state <= state_nxt;
  end

  // Token-emitting decisions wait for a free output slot; pure accumulation does not.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    first_nxt = first;
    pop_c     = 1'b0;
    emit_c    = 1'b0;
    ekind_c   = KIND_NUM;
    evalue_c  = '0;
    if (head_valid) begin
      case (state)
        ST_SKIP: begin
          if (is_ws(head)) begin
            pop_c = 1'b1;
          end else if (is_digit(head)) begin
            acc_nxt   = VALUE_W'(head - CH_0);
            state_nxt = ST_NUM;
            pop_c     = 1'b1;
          end else if (is_alpha(head)) begin
            acc_nxt   = VALUE_W'(head);
            cnt_nxt   = CNT_W'(1);
            state_nxt = ST_IDENT;
            pop_c     = 1'b1;
          end else if (is_op2(head)) begin
            first_nxt = head;
            state_nxt = ST_OP2;
            pop_c     = 1'b1;
          end else if (out_free_c) begin
            emit_c = 1'b1;
            pop_c  = 1'b1;
            if (head == CH_NUL) begin
              ekind_c   = KIND_EOF;
              state_nxt = ST_DONE;
            end else if (is_sym(head)) begin
              ekind_c  = KIND_SYM;
              evalue_c = VALUE_W'(head);
            end else begin
              ekind_c  = KIND_ERR;
              evalue_c = VALUE_W'(head);
            end
          end
        end
        ST_NUM: begin
          if (is_digit(head)) begin
            acc_nxt = (acc << 3) + (acc << 1) + VALUE_W'(head - CH_0);
            pop_c   = 1'b1;
          end else if (out_free_c) begin
            emit_c    = 1'b1;
            ekind_c   = KIND_NUM;
            evalue_c  = acc;
            state_nxt = ST_SKIP;
          end
        end
        ST_IDENT: begin
          if (is_alpha(head) || is_digit(head)) begin
            if (cnt < CNT_W'(4)) begin
              acc_nxt = {acc[VALUE_W-BYTE_W-1:0], head};
              cnt_nxt = cnt + CNT_W'(1);
            end
            pop_c = 1'b1;
          end else if (out_free_c) begin
            emit_c    = 1'b1;
            ekind_c   = KIND_IDENT;
            evalue_c  = acc;
            state_nxt = ST_SKIP;
          end
        end
        ST_OP2: begin
          if (out_free_c) begin
            emit_c    = 1'b1;
            state_nxt = ST_SKIP;
            if (head == CH_EQ) begin
              ekind_c  = KIND_SYM;
              evalue_c = {16'h0, first, CH_EQ};
              pop_c    = 1'b1;
            end else if (first == CH_BANG) begin
              ekind_c  = KIND_ERR;
              evalue_c = VALUE_W'(CH_BANG);
            end else begin
              ekind_c  = KIND_SYM;
              evalue_c = VALUE_W'(first);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CCLK) begin
    if (CRST) begin
      acc   <= '0;
      cnt   <= '0;
      first <= '0;
    end else begin
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      first <= first_nxt;
    end
  end

  // Output slot reloads when empty or when its current token is accepted.
  always_ff @(posedge CCLK) begin
    if (CRST) begin
      O_VALID <= 1'b0;
      O_KIND  <= '0;
      O_VALUE <= '0;
      O_DONE  <= 1'b0;
    end else begin
      if (out_free_c) begin
        O_VALID <= emit_c;
        if (emit_c) begin
          O_KIND  <= ekind_c;
          O_VALUE <= evalue_c;
        end
      end
      if (O_VALID && O_READY && (O_KIND == KIND_EOF)) O_DONE <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lexer.sv
// Directed bench for lexer: FIFO model feeding bytes, scoreboard of expected
// tokens checked on every output handshake.
module tb_lexer;

  logic        CCLK = 1'b0;
  logic        CRST = 1'b1;
  logic        I_EMPTY = 1'b1;
  logic        I_RDEN;
  logic        I_VALID = 1'b0;
  logic [7:0]  I_DATA = 8'h00;
  logic        O_VALID;
  logic        O_READY = 1'b1;
  logic [3:0]  O_KIND;
  logic [31:0] O_VALUE;
  logic        O_DONE;

  int          n_tests = 0;
  int          n_fail  = 0;
  string       cur_test = "init";
  logic [7:0]  src[$];
  logic [35:0] exp_q[$];
  logic        starve = 1'b0;
  logic        rnd_ready = 1'b0;

  lexer dut (
    .CCLK    (CCLK),
    .CRST    (CRST),
    .I_EMPTY (I_EMPTY),
    .I_RDEN  (I_RDEN),
    .I_VALID (I_VALID),
    .I_DATA  (I_DATA),
    .O_VALID (O_VALID),
    .O_READY (O_READY),
    .O_KIND  (O_KIND),
    .O_VALUE (O_VALUE),
    .O_DONE  (O_DONE)
  );

  always #5 CCLK = ~CCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", cur_test, tag, obs, expv);
    end
  endtask

  // FIFO model: one-cycle read latency, empty flag follows the source queue.
  initial begin
    logic rd_s;
    forever begin
      @(negedge CCLK);
      rd_s = I_RDEN && !I_EMPTY;
      @(posedge CCLK);
      #1;
      I_VALID = rd_s && (src.size() > 0);
      if (I_VALID) I_DATA = src.pop_front();
      I_EMPTY = (src.size() == 0) || starve;
    end
  end

  initial begin
    forever begin
      @(posedge CCLK);
      #1;
      O_READY = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard and stall-stability monitor.
  initial begin
    logic        prev_stall;
    logic [3:0]  prev_kind;
    logic [31:0] prev_value;
    logic [35:0] e;
    prev_stall = 1'b0;
    prev_kind  = '0;
    prev_value = '0;
    forever begin
      @(negedge CCLK);
      if (CRST) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(O_VALID), 32'd1);
          check("stall_kind", 32'(O_KIND), 32'(prev_kind));
          check("stall_value", O_VALUE, prev_value);
        end
        if (O_VALID && O_READY) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s/spurious_token: observed kind %0d value 0x%0h expected none",
                   cur_test, O_KIND, O_VALUE);
          end else begin
            e = exp_q.pop_front();
            check("tok_kind", 32'(O_KIND), 32'(e[35:32]));
            check("tok_value", O_VALUE, e[31:0]);
          end
        end
        prev_stall = O_VALID && !O_READY;
        prev_kind  = O_KIND;
        prev_value = O_VALUE;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CCLK);
      #1;
    end
  endtask

  task automatic push_str(input string s, input logic nul);
    for (int i = 0; i < s.len(); i++) src.push_back(s[i]);
    if (nul) src.push_back(8'h00);
  endtask

  task automatic exp_tok(input logic [3:0] k, input logic [31:0] v);
    exp_q.push_back({k, v});
  endtask

  task automatic do_reset();
    src.delete();
    CRST = 1'b1;
    tick(2);
    check("rst_rden", 32'(I_RDEN), 32'd0);
    check("rst_valid", 32'(O_VALID), 32'd0);
    check("rst_kind", 32'(O_KIND), 32'd0);
    check("rst_value", O_VALUE, 32'd0);
    check("rst_done", 32'(O_DONE), 32'd0);
    CRST = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!O_DONE && n < 500) begin
      tick(1);
      n++;
    end
    check("done", 32'(O_DONE), 32'd1);
    check("drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    cur_test = "reset";
    do_reset();

    cur_test = "basic";
    exp_tok(4'd0, 32'd12);
    exp_tok(4'd1, 32'h2B);
    exp_tok(4'd2, 32'h6162);
    exp_tok(4'd1, 32'h3B);
    exp_tok(4'd3, 32'h0);
    push_str("12+ab;", 1'b1);
    wait_done();
    push_str("zz", 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("idle_rden", 32'(I_RDEN), 32'd0);
      check("idle_done", 32'(O_DONE), 32'd1);
    end

    cur_test = "ops";
    do_reset();
    exp_tok(4'd2, 32'h61);
    exp_tok(4'd1, 32'h3C3D);
    exp_tok(4'd2, 32'h62);
    exp_tok(4'd1, 32'h213D);
    exp_tok(4'd2, 32'h63);
    exp_tok(4'd4, 32'h21);
    exp_tok(4'd2, 32'h78);
    exp_tok(4'd3, 32'h0);
    push_str("a<=b != c!x", 1'b1);
    wait_done();

    cur_test = "wrap";
    do_reset();
    exp_tok(4'd0, 32'd1);
    exp_tok(4'd2, 32'h61626364);
    exp_tok(4'd3, 32'h0);
    push_str("4294967297 abcdefg", 1'b1);
    wait_done();

    cur_test = "backpressure";
    do_reset();
    rnd_ready = 1'b1;
    exp_tok(4'd0, 32'd1);
    exp_tok(4'd1, 32'h2B);
    exp_tok(4'd0, 32'd2);
    exp_tok(4'd3, 32'h0);
    push_str("1+2", 1'b1);
    wait_done();
    rnd_ready = 1'b0;

    cur_test = "starve";
    do_reset();
    exp_tok(4'd0, 32'd123);
    exp_tok(4'd3, 32'h0);
    push_str("12", 1'b0);
    tick(10);
    starve = 1'b1;
    push_str("3", 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("starve_valid", 32'(O_VALID), 32'd0);
    end
    starve = 1'b0;
    push_str(" ", 1'b1);
    wait_done();

    cur_test = "midreset";
    do_reset();
    push_str("45", 1'b0);
    tick(10);
    check("pre_reset_valid", 32'(O_VALID), 32'd0);
    do_reset();
    check("pre_reset_queue", 32'(exp_q.size()), 32'd0);
    exp_tok(4'd0, 32'd7);
    exp_tok(4'd1, 32'h3B);
    exp_tok(4'd3, 32'h0);
    push_str("7;", 1'b1);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lexer.md
# lexer

Tokenizer stage of the CPU core, directly downstream of the instruction/source fetch FIFO (32-bit in, 8-bit out, standard 1-cycle read latency). Pulls ASCII bytes from the FIFO, skips whitespace, and emits one token per valid/ready handshake to the parser stage. It terminates on a NUL byte.

## Interface
- No parameters; widths are fixed: 8-bit byte, 32-bit token value, 4-bit token kind.
- CCLK  in  1  core clock; the only clock.
- CRST  in  1  synchronous active-high reset.
- I_EMPTY  in  1  FIFO empty flag.
- I_RDEN  out  1  FIFO read enable.
- I_VALID  in  1  FIFO read data valid, one cycle after the I_RDEN that requested it.
- I_DATA  in  8  FIFO read byte.
- O_VALID  out  1  token valid.
- O_READY  in  1  downstream accepts the token.
- O_KIND  out  4  token kind.
- O_VALUE  out  32  token payload.
- O_DONE  out  1  EOF token accepted; the lexer is idle until reset.

## Operation
- Token kinds: NUM=0, SYM=1, IDENT=2, EOF=3, ERR=4.
- Input buffer: 2 entries, FIFO order.
  - I_RDEN = !I_EMPTY && !DONE && (occupancy + inflight) < 2, evaluated with this cycle's pop. This gives 1 byte/cycle sustained.
  - I_VALID pushes I_DATA.
  - The in-flight flag is set by I_RDEN and cleared on the following cycle.
- The head byte is examined only in states SKIP, NUM, IDENT and OP2. The head is popped only when consumed; a terminator is left in place and reprocessed in SKIP.
- Emission stall: if O_VALID && !O_READY and the current head would emit a token, the head is not consumed and state holds.
- SKIP state, by head byte:
  - space, 0x09, 0x0A, 0x0D: pop.
  - '0'-'9': load value=digit, go to NUM.
  - [A-Za-z_]: load value=char, count=1, go to IDENT.
  - '=', '!', '<', '>': latch the char, go to OP2.
  - '+' '-' '*' '/' '(' ')' '{' '}' ';' ',' '&': emit SYM with value = the char.
  - 0x00: emit EOF with value 0, go to DONE.
  - Any other byte: emit ERR with value = the byte.
- NUM state:
  - On a digit: value = value*10 + digit, truncated mod 2^32 (wraps silently), then pop.
  - Otherwise: emit NUM without popping, go to SKIP.
- IDENT state:
  - On [A-Za-z0-9_]: if count < 4, value = {value[23:0], char}. Characters beyond the 4th are popped and discarded. Then pop.
  - Otherwise: emit IDENT without popping, go to SKIP.
- OP2 state:
  - If the head is '=': emit SYM with value = {16'h0, first, 8'h3D} and pop.
  - Otherwise: emit single SYM with value = first, without popping. A lone '!' instead emits ERR with value 0x21.
  - Return to SKIP in both cases.
- DONE state: I_RDEN stays low and no bytes are consumed. O_DONE rises the cycle after the EOF handshake.
- Output register:
  - Loaded when empty or when being accepted in the same cycle (O_VALID && O_READY) — back-to-back tokens.
  - O_KIND and O_VALUE stay stable while O_VALID && !O_READY.

## Timing
- Reset values: I_RDEN=0, O_VALID=0, O_KIND=0, O_VALUE=0, O_DONE=0. Buffer is empty, in-flight flag clear, state SKIP.
- CRST mid-token discards the partial token, the buffered bytes and any pending output.
- An I_VALID arriving while the in-flight flag is clear is dropped.
- Single-char SYM: head byte visible at cycle t gives O_VALID at t+1.
- NUM and IDENT: token appears 1 cycle after the terminator reaches the head. The terminator is then processed at t+2.
- The FIFO going empty mid-token only stalls the lexer; no token is emitted early.
- Simultaneous push and pop with occupancy 2 is legal and cannot overflow, because of the I_RDEN rule.

## Structure
- `lexer_pkg` holds:
  - token-kind constants;
  - ASCII constants (space, tab, LF, CR, NUL, '=', '!', '<', '>', digit/letter bounds);
  - state encoding (SKIP, NUM, IDENT, OP2, DONE).
- Sub-module `lexer_ibuf` contains the 2-entry byte buffer plus the I_RDEN/in-flight logic. It exposes head, head_valid and pop.
- The FSM, the accumulator and the output register live in `lexer`.

## Test plan
- "12+ab;\0" with O_READY=1 produces, in order:
  - NUM 12
  - SYM 0x2B
  - IDENT 0x6162
  - SYM 0x3B
  - EOF 0
  - then O_DONE=1 and I_RDEN stays 0.
- "a<=b != c!x\0" produces:
  - IDENT 0x61
  - SYM 0x3C3D
  - IDENT 0x62
  - SYM 0x213D
  - IDENT 0x63
  - ERR 0x21
  - IDENT 0x78
  - EOF
- "4294967297 abcdefg\0" produces NUM 1 (wrap), then IDENT 0x61626364, then EOF.
- Backpressure: O_READY toggling randomly on "1+2\0" yields the same token sequence, with O_KIND/O_VALUE stable while stalled and no byte lost or duplicated.
- FIFO starvation: I_EMPTY held high for 10 cycles mid "123" leaves O_VALID=0 throughout; when " \0" follows, the lexer emits NUM 123 and then EOF.
- CRST asserted while in NUM after "45": all outputs go to their reset values. The next input "7;\0" produces NUM 7, SYM 0x3B, EOF, with no trace of 45.
